// File: rtl/spi_pkg.sv
// spi_pkg: SPI receive state encoding and default word/preamble sizes shared with the master.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SKIP, SHIFT} spi_rx_state_t;
    localparam int SPI_DATA_W     = 8;
    localparam int SPI_SKIP_EDGES = 1;
endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: show-ahead receive FIFO; a push that finds it full with no pop is dropped and flagged.
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              overrun_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic              empty, full, pop, wr_en, overrun_q;
    assign empty = wr_q == rd_q;
    assign full  = PW'(wr_q - rd_q) == PW'(DEPTH);
    assign pop   = ~empty & ready_i;
    // the slot freed by a pop this cycle can take the incoming word
    assign wr_en = push_i & (~full | pop);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q      <= '0;
            rd_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_q      <= wr_q + PW'(wr_en);
            rd_q      <= rd_q + PW'(pop);
            overrun_q <= push_i & full & ~pop;
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
    end
    assign valid_o   = ~empty;
    assign data_o    = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign overrun_o = overrun_q;
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling SPI receiver with preamble skip and valid/ready output.
// Defining SPI_RX_FIFO_EN replaces the single holding register with a spi_rx_fifo.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int SKIP_EDGES  = SPI_SKIP_EDGES,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sclk_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);
    localparam int BW  = $clog2(DATA_W);
    localparam int SKW = SKIP_EDGES > 1 ? $clog2(SKIP_EDGES) : 1;
    if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("spi_slave_rx: SYNC_STAGES must be >= 2 and FIFO_DEPTH a power of 2 >= 2");
    end
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, settle_q;
    logic                   sclk_prev_q, cs_prev_q, armed_q;
    logic                   sclk_s, cs_s, mosi_s, rise, cs_rise, cs_fall;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            settle_q    <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            armed_q     <= armed_q | (settle_q[SYNC_STAGES-1] & cs_s);
        end
    end
    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev_q;
    assign cs_rise = cs_s & ~cs_prev_q;
    // a select that was already low when reset released must go high before a frame is accepted
    assign cs_fall = armed_q & ~cs_s & cs_prev_q;
    spi_rx_state_t     state_q;
    logic [DATA_W-1:0] shift_q, word_d;
    logic [BW-1:0]     bit_cnt_q;
    logic [SKW-1:0]    skip_cnt_q;
    logic              frame_err_q, push_d;
    assign word_d = {shift_q[DATA_W-2:0], mosi_s};
    assign push_d = state_q == SHIFT && rise && !cs_rise && bit_cnt_q == BW'(DATA_W - 1);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            skip_cnt_q  <= '0;
            frame_err_q <= 1'b0;
        end else if (cs_rise) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            skip_cnt_q  <= '0;
            frame_err_q <= state_q == SHIFT && bit_cnt_q != '0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    shift_q    <= '0;
                    bit_cnt_q  <= '0;
                    skip_cnt_q <= '0;
                    if (cs_fall) state_q <= SKIP_EDGES == 0 ? SHIFT : SKIP;
                end
                SKIP: if (rise) begin
                    skip_cnt_q <= skip_cnt_q == SKW'(SKIP_EDGES - 1) ? '0 : skip_cnt_q + 1'b1;
                    state_q    <= skip_cnt_q == SKW'(SKIP_EDGES - 1) ? SHIFT : SKIP;
                end
                SHIFT: if (rise) begin
                    shift_q   <= word_d;
                    bit_cnt_q <= bit_cnt_q == BW'(DATA_W - 1) ? '0 : bit_cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign frame_err_o = frame_err_q;
    assign busy_o      = ~cs_s;
`ifdef SPI_RX_FIFO_EN
    spi_rx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_i   (push_d),
        .data_i   (word_d),
        .ready_i  (rx_ready_i),
        .valid_o  (rx_valid_o),
        .data_o   (rx_data_o),
        .overrun_o(overrun_o)
    );
`else
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q, overrun_q, hold;
    assign hold = rx_valid_q & ~rx_ready_i;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= push_d & hold;
            if (push_d && !hold) begin
                rx_data_q  <= word_d;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign overrun_o  = overrun_q;
`endif
endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Receive-side SPI endpoint that sits directly downstream of the team's SPI master on the same `mosi`/`cs`/`sclk` wires. It oversamples the three SPI lines in the system clock domain, discards the master's start-of-frame preamble clock pulse, shifts in MSB-first bytes on synchronised `sclk` rising edges, and presents each byte on a valid/ready stream. Partial frames and overruns are flagged.

## Interface
- `DATA_W`, 8: bits per word.
- `SYNC_STAGES`, 2: flip-flop stages on `sclk`, `cs` and `mosi`; minimum 2.
- `SKIP_EDGES`, 1: `sclk` rising edges after `cs` falls that are ignored (preamble).
- `FIFO_DEPTH`, 4: FIFO entries when `SPI_RX_FIFO_EN` is defined; power of 2.

Ports:
- `clk`  in  1  system clock; must be at least 4× the `sclk` rate.
- `rst`  in  1  reset, asynchronous, active-low.
- `sclk`  in  1  SPI clock from the master, asynchronous to `clk`.
- `cs`  in  1  chip select, active-low.
- `mosi`  in  1  serial data, MSB first.
- `rx_data`  out  DATA_W  received word.
- `rx_valid`  out  1  `rx_data` holds a word.
- `rx_ready`  in  1  consumer accepts the word when `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse when `cs` rises with a partial word.
- `overrun`  out  1  one-cycle pulse when a completed word is dropped.
- `busy`  out  1  high while the synchronised `cs` is low.

## Operation
- All three SPI inputs use identical `SYNC_STAGES` synchronisers, so their relative timing is preserved. An edge register `sclk_d` holds the previous synchronised `sclk`.
- `rise = sclk_s & ~sclk_d`. `cs_fall` and `cs_rise` are derived the same way from synchronised `cs`.
- State machine states are IDLE, SKIP and SHIFT.
  - IDLE: the shifter, bit count and skip count are cleared. On `cs_fall`, go to SKIP; if `SKIP_EDGES`=0, go directly to SHIFT.
  - SKIP: each `rise` increments the skip count. When the count reaches `SKIP_EDGES`, go to SHIFT. `mosi` is ignored in SKIP.
  - SHIFT: each `rise` does `shift <= {shift[DATA_W-2:0], mosi_s}` and increments the bit count.
    - On the `DATA_W`-th rise, push `{shift[DATA_W-2:0], mosi_s}` to the output stage, clear the bit count and stay in SHIFT. Multi-word frames are supported.
  - Any state: `cs_rise` returns to IDLE. If in SHIFT with a nonzero bit count, pulse `frame_err` and discard the partial word. `cs_rise` in SKIP is silent.
- Output stage without the macro: a single holding register.
  - A push while `rx_valid` is high and `rx_ready` is low: the new word is dropped, the old word is kept, and `overrun` pulses.
  - A push in the same cycle as a pop: the new word is accepted and there is no overrun.
- `rise` and `cs_rise` in the same cycle: `cs_rise` wins and the edge is not sampled.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - State IDLE, all counters 0.
  - Synchroniser flops reset to `sclk`=0, `cs`=1, `mosi`=0.
- Latency: a word becomes valid `SYNC_STAGES` `clk` edges after the first edge that captures the raw final `sclk`=1. That is 2 cycles at the default setting.
- `rx_valid` stays high with `rx_data` stable until the handshake. It deasserts on the edge after `rx_valid & rx_ready`, unless another word is already queued.
- `frame_err` and `overrun` are single-cycle pulses, registered.
- Reset asserted mid-frame clears everything immediately. After release, the block waits in IDLE for a fresh `cs_fall`; a frame already in progress is not received.

## Configuration
- `SPI_RX_FIFO_EN` defined: the output stage is a `FIFO_DEPTH`-entry FIFO with show-ahead `rx_data`.
  - `overrun` pulses only when a push arrives with the FIFO full and no pop in that cycle; the new word is dropped.
  - Push and pop in the same cycle at full or empty are both honoured.
  - Pointers are `$clog2(FIFO_DEPTH)`+1 bits wide and wrap naturally.
- Undefined: the single holding register described above, and `FIFO_DEPTH` is unused.

## Structure
- Shared package `spi_pkg` holds the `spi_rx_state_t` enum (IDLE, SKIP, SHIFT) and default constants for `DATA_W` and `SKIP_EDGES`, also used by the master.
- One sub-module, `spi_rx_fifo`, is instantiated only under `SPI_RX_FIFO_EN`.
- The synchronisers are inline; no separate module.

## Test plan
- Master-style frame: `cs` falls, one preamble `sclk` pulse, then 8 pulses carrying 0xAA, then `cs` rises, with `rx_ready`=1 -> exactly one word 0xAA, no `frame_err`.
- Two back-to-back words 0x3C and 0xC3 in one `cs` frame with `rx_ready`=1 -> words 0x3C then 0xC3 in order.
- `cs` rises after 5 data bits -> `frame_err` pulses once and no word is produced. The next full frame carrying 0x55 is received correctly.
- `rx_ready`=0 through three consecutive words 0x01, 0x02, 0x03:
  - Without the macro -> 0x01 is held and `overrun` pulses twice.
  - With the macro -> all three words are queued and there is no `overrun`.
- Reset asserted mid-word, then released while `cs` is still low -> no output for that frame. The next frame carrying 0x81 is received correctly.
- `SKIP_EDGES`=0 and a frame with no preamble carrying 0xF0 -> word 0xF0 is received.
